clock_display: RTL and testbench

- Downstream consumer of the time-of-day counter.
- Takes binary sec/min/hr and drives a 6-digit multiplexed common-anode 7-segment display (HH MM SS).
- Performs binary-to-BCD conversion, 12/24-hour formatting and tear-free frame capture.
- Blinks the minute or hour field while the time is being set.

---
 rtl/clock_display.sv | 178 +++++++++++++++++
 tb/tb_clock_display.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/clock_display.sv
// Six-digit multiplexed common-anode display driver (HH MM SS) fed by a binary time-of-day counter.
// Captures a tear-free snapshot per frame, formats 12/24h, converts to BCD and blinks fields while setting.
module clock_display #(
  parameter int SCAN_DIV    = 50000,
  parameter int BLINK_SCANS = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic [4:0] hr,
  input  logic       mode12,
  input  logic       blink_min,
  input  logic       blink_hr,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic [5:0] an_n,
  output logic       pm
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  logic [SW-1:0] scan_cnt;
  logic [BW-1:0] blink_cnt;
  logic [2:0]    idx;
  logic          blink_phase;
  logic          primed;
  logic          adv;
  logic          load;

  logic [5:0] s_sec;
  logic [5:0] s_min;
  logic [4:0] s_hr;
  logic       s_mode12;

  logic       sec_ok, min_ok, hr_ok;
  logic [4:0] hr_disp;
  logic [7:0] sec_bcd, min_bcd, hr_bcd;
  logic [3:0] digit;
  logic       dash, lead_blank, blink_off;
  logic [6:0] seg_next;
  logic       dp_next;
  logic [5:0] an_next;
  logic       pm_next;

  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [3:0] t;
    logic [5:0] r;
    if (v >= 6'd50)      begin t = 4'd5; r = v - 6'd50; end
    else if (v >= 6'd40) begin t = 4'd4; r = v - 6'd40; end
    else if (v >= 6'd30) begin t = 4'd3; r = v - 6'd30; end
    else if (v >= 6'd20) begin t = 4'd2; r = v - 6'd20; end
    else if (v >= 6'd10) begin t = 4'd1; r = v - 6'd10; end
    else                 begin t = 4'd0; r = v;          end
    return {t, r[3:0]};
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  assign adv  = (scan_cnt == SW'(SCAN_DIV - 1));
  // Frame boundary load coincides with the idx 5->0 wrap, so a frame never mixes two captures.
  assign load = !primed || (adv && idx == 3'd5);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt    <= '0;
      idx         <= 3'd0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      primed      <= 1'b0;
    end else begin
      primed <= 1'b1;
      if (adv) begin
        scan_cnt <= '0;
        idx      <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
        if (blink_cnt == BW'(BLINK_SCANS - 1)) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end else begin
        scan_cnt <= scan_cnt + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_sec    <= 6'd0;
      s_min    <= 6'd0;
      s_hr     <= 5'd0;
      s_mode12 <= 1'b0;
    end else if (load) begin
      s_sec    <= sec;
      s_min    <= min;
      s_hr     <= hr;
      s_mode12 <= mode12;
    end
  end

  always_comb begin
    sec_ok = (s_sec <= 6'd59);
    min_ok = (s_min <= 6'd59);
    hr_ok  = (s_hr <= 5'd23);
    if (!s_mode12)          hr_disp = s_hr;
    else if (s_hr == 5'd0)  hr_disp = 5'd12;
    else if (s_hr > 5'd12)  hr_disp = s_hr - 5'd12;
    else                    hr_disp = s_hr;
    pm_next = s_mode12 && hr_ok && (s_hr >= 5'd12);
    sec_bcd = to_bcd(s_sec);
    min_bcd = to_bcd(s_min);
    hr_bcd  = to_bcd({1'b0, hr_disp});
  end

  always_comb begin
    digit      = 4'd0;
    dash       = 1'b0;
    lead_blank = 1'b0;
    case (idx)
      3'd0: begin digit = sec_bcd[3:0]; dash = !sec_ok; end
      3'd1: begin digit = sec_bcd[7:4]; dash = !sec_ok; end
      3'd2: begin digit = min_bcd[3:0]; dash = !min_ok; end
      3'd3: begin digit = min_bcd[7:4]; dash = !min_ok; end
      3'd4: begin digit = hr_bcd[3:0];  dash = !hr_ok;  end
      3'd5: begin
        digit      = hr_bcd[7:4];
        dash       = !hr_ok;
        lead_blank = s_mode12 && (hr_bcd[7:4] == 4'd0);
      end
      default: ;
    endcase
    blink_off = blink_phase &&
                ((blink_min && (idx == 3'd2 || idx == 3'd3)) ||
                 (blink_hr  && (idx == 3'd4 || idx == 3'd5)));
    if (blink_off)       seg_next = SEG_BLANK;
    else if (dash)       seg_next = SEG_DASH;
    else if (lead_blank) seg_next = SEG_BLANK;
    else                 seg_next = seg_code(digit);
    dp_next = !(!blink_phase && (idx == 3'd2 || idx == 3'd4));
    an_next = ~(6'd1 << idx);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_n <= SEG_BLANK;
      dp_n  <= 1'b1;
      an_n  <= 6'h3F;
      pm    <= 1'b0;
    end else begin
      seg_n <= seg_next;
      dp_n  <= dp_next;
      an_n  <= an_next;
      pm    <= pm_next;
    end
  end

endmodule

// File: tb/tb_clock_display.sv
// Scoreboarded bench for clock_display: each digit slot's final-cycle outputs are compared
// against hand-computed per-frame expectations pushed at the start of every frame.
module tb_clock_display;
  localparam int SCAN_DIV    = 4;
  localparam int BLINK_SCANS = 3;
  localparam int NVEC        = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] sec, min;
  logic [4:0] hr;
  logic       mode12, blink_min, blink_hr;
  logic [6:0] seg_n;
  logic       dp_n;
  logic [5:0] an_n;
  logic       pm;

  clock_display #(.SCAN_DIV(SCAN_DIV), .BLINK_SCANS(BLINK_SCANS)) dut (
    .clk(clk), .rst(rst), .sec(sec), .min(min), .hr(hr), .mode12(mode12),
    .blink_min(blink_min), .blink_hr(blink_hr),
    .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n), .pm(pm)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]       sec;
    logic [5:0]       min;
    logic [4:0]       hr;
    logic             m12;
    logic             bmin;
    logic             bhr;
    logic [0:5][6:0]  segs;
    logic             pm;
  } vec_t;

  typedef struct {
    int         k;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       pm;
  } exp_t;

  vec_t vec [0:NVEC];
  exp_t exp_q [$];
  int   checks   = 0;
  int   failures = 0;

  logic [5:0] an_tab [0:5];
  logic [5:0] last_an = 6'h3F;
  logic [6:0] last_seg;
  logic       last_dp, last_pm;

  task automatic check(input string name, input int k, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s slot=%0d got=%h expected=%h", name, k, act, expv);
    end
  endtask

  task automatic wait_an(input logic [5:0] v, output int n);
    logic [5:0] prev;
    prev = an_n;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (an_n === v && prev !== v) return;
      prev = an_n;
    end
    checks++;
    failures++;
    $display("FAIL timeout waiting for an_n=%h got=%h", v, an_n);
  endtask

  task automatic apply_time(input int i);
    sec = vec[i].sec; min = vec[i].min; hr = vec[i].hr; mode12 = vec[i].m12;
  endtask

  task automatic apply_blink(input int i);
    blink_min = vec[i].bmin; blink_hr = vec[i].bhr;
  endtask

  task automatic push_frame(input int i);
    exp_t e;
    for (int k = 0; k < 6; k++) begin
      e.k   = k;
      e.an  = an_tab[k];
      e.seg = vec[i].segs[k];
      e.dp  = (k == 2) ? 1'b0 : 1'b1;
      e.pm  = vec[i].pm;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: a change of an_n closes a digit slot; its last-cycle outputs are checked.
  always @(negedge clk) begin
    exp_t e;
    if (an_n !== last_an && last_an !== 6'h3F && an_n !== 6'h3F && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("an_n", e.k, {2'b0, last_an}, {2'b0, e.an});
      check("seg_n", e.k, {1'b0, last_seg}, {1'b0, e.seg});
      check("dp_n", e.k, {7'b0, last_dp}, {7'b0, e.dp});
      check("pm", e.k, {7'b0, last_pm}, {7'b0, e.pm});
    end
    last_an  = an_n;
    last_seg = seg_n;
    last_dp  = dp_n;
    last_pm  = pm;
  end

  initial begin
    int n;
    an_tab = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
    vec[0]  = '{6'd9,  6'd5,  5'd13, 1'b0, 1'b0, 1'b0, {7'h10,7'h40,7'h12,7'h40,7'h30,7'h79}, 1'b0};
    vec[1]  = '{6'd9,  6'd5,  5'd13, 1'b1, 1'b0, 1'b0, {7'h10,7'h40,7'h12,7'h40,7'h79,7'h7F}, 1'b1};
    vec[2]  = '{6'd9,  6'd5,  5'd0,  1'b1, 1'b0, 1'b0, {7'h10,7'h40,7'h12,7'h40,7'h24,7'h79}, 1'b0};
    vec[3]  = '{6'd9,  6'd5,  5'd12, 1'b1, 1'b0, 1'b0, {7'h10,7'h40,7'h12,7'h40,7'h24,7'h79}, 1'b1};
    vec[4]  = '{6'd10, 6'd5,  5'd13, 1'b0, 1'b0, 1'b0, {7'h40,7'h79,7'h12,7'h40,7'h30,7'h79}, 1'b0};
    vec[5]  = '{6'd10, 6'd60, 5'd24, 1'b1, 1'b0, 1'b0, {7'h40,7'h79,7'h3F,7'h3F,7'h3F,7'h3F}, 1'b0};
    vec[6]  = '{6'd59, 6'd59, 5'd23, 1'b0, 1'b0, 1'b1, {7'h10,7'h12,7'h10,7'h12,7'h7F,7'h7F}, 1'b0};
    vec[7]  = '{6'd0,  6'd0,  5'd0,  1'b0, 1'b1, 1'b0, {7'h40,7'h40,7'h40,7'h7F,7'h40,7'h40}, 1'b0};
    vec[8]  = '{6'd59, 6'd59, 5'd23, 1'b1, 1'b0, 1'b0, {7'h10,7'h12,7'h10,7'h12,7'h79,7'h79}, 1'b1};
    vec[9]  = '{6'd60, 6'd0,  5'd9,  1'b1, 1'b0, 1'b0, {7'h3F,7'h3F,7'h40,7'h40,7'h10,7'h7F}, 1'b0};
    vec[10] = '{6'd33, 6'd44, 5'd22, 1'b0, 1'b0, 1'b0, {7'h30,7'h30,7'h19,7'h19,7'h24,7'h24}, 1'b0};

    rst = 1'b1;
    apply_time(0);
    apply_blink(0);
    repeat (3) @(negedge clk);
    #1;
    check("rst_an_n", 0, {2'b0, an_n}, 8'h3F);
    check("rst_seg_n", 0, {1'b0, seg_n}, 8'h7F);
    check("rst_dp_n", 0, {7'b0, dp_n}, 8'h01);
    check("rst_pm", 0, {7'b0, pm}, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Each frame's expectations are pushed at its start; next inputs change mid-frame at idx 2.
    for (int i = 0; i < NVEC; i++) begin
      wait_an(6'h3E, n);
      #1;
      apply_blink(i);
      push_frame(i);
      wait_an(6'h3B, n);
      if (i < NVEC - 1) apply_time(i + 1);
    end

    wait_an(6'h3E, n);
    apply_time(10);
    apply_blink(10);
    wait_an(6'h37, n);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_an_n", 3, {2'b0, an_n}, 8'h3F);
    check("midrst_seg_n", 3, {1'b0, seg_n}, 8'h7F);
    check("midrst_dp_n", 3, {7'b0, dp_n}, 8'h01);
    check("midrst_pm", 3, {7'b0, pm}, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_an(6'h3E, n);
    check("first_idx0_cycles", 0, 8'(n), 8'd1);
    #1;
    push_frame(10);
    wait_an(6'h3E, n);
    #1;
    check("queue_drained", 0, 8'(exp_q.size()), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
